// File: rtl/hnf_pkg.sv
// Shared types for the HN-F point-of-coherence queue: request/response flits,
// the opcodes this block cares about, and the per-entry lifecycle state.
package hnf_pkg;

   localparam int ADDR_W = 48;
   localparam int TXN_W  = 8;
   localparam int NODE_W = 7;

   localparam logic [6:0] OPC_READSHARED = 7'h01;
   localparam logic [6:0] OPC_READNOSNP  = 7'h04;
   localparam logic [4:0] RSP_COMPACK    = 5'h02;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [6:0]        opcode;
      logic [TXN_W-1:0]  txnid;
      logic [NODE_W-1:0] srcid;
      logic [TXN_W-1:0]  return_txnid;
   } reqflit_t;

   typedef struct packed {
      logic [4:0]        opcode;
      logic [TXN_W-1:0]  txnid;
      logic [NODE_W-1:0] srcid;
   } rspflit_t;

   typedef enum logic [2:0] {
      POCQ_FREE     = 3'd0,
      POCQ_SLEEP    = 3'd1,
      POCQ_READY    = 3'd2,
      POCQ_ISSUED   = 3'd3,
      POCQ_WAIT_ACK = 3'd4
   } pocq_state_e;

endpackage

// File: rtl/pocq_ffs.sv
// Lowest-index find-first-set: returns the index of the lowest set bit of vec
// and whether any bit was set at all.
module pocq_ffs #(
   parameter int  W  = 16,
   localparam int IW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          found
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = IW'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hnf_pocq_ctrl.sv
// HN-F point-of-coherence queue. Accepts RN requests, chains same-line
// requests behind the youngest live entry for that line, issues ReadNoSnp to
// the SN and retires an entry on SN data followed by RN CompAck.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both 1
// at the rising clock edge. Once snreq_valid rises, snreq_flit holds the same
// entry until snreq_ready; valid never drops without a transfer (except reset).
module hnf_pocq_ctrl
   import hnf_pkg::*;
#(
   parameter int  DEPTH     = 16,
   parameter int  LINE_LSB  = 6,
   parameter int  HAZARD_EN = 1,
   localparam int IDX_W     = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  reqflit_t              req_flit,
   output logic                  snreq_valid,
   input  logic                  snreq_ready,
   output reqflit_t              snreq_flit,
   input  logic                  dat_valid,
   input  logic [IDX_W-1:0]      dat_txnid,
   input  logic                  rsp_valid,
   input  rspflit_t              rsp_flit,
   output logic [IDX_W:0]        count,
   output logic                  full,
   output logic                  empty,
   output logic                  err,
   output logic [DEPTH-1:0][2:0] dbg_state
);

   pocq_state_e       state_q   [DEPTH];
   logic [ADDR_W-1:0] addr_q    [DEPTH];
   logic [TXN_W-1:0]  txn_q     [DEPTH];
   logic [IDX_W-1:0]  blocker_q [DEPTH];
   logic [DEPTH-1:0]  tail_q;
   logic [IDX_W:0]    count_q;
   logic              hold_vld_q;
   logic [IDX_W-1:0]  hold_idx_q;
   logic              err_q;

   logic [DEPTH-1:0]  free_vec, ready_vec, match_vec;
   logic [DEPTH-1:0]  alloc_oh, issue_oh, dat_oh, retire_oh, hz_oh;
   logic [IDX_W-1:0]  alloc_idx, rdy_idx, hz_idx, sel_idx, rsp_idx;
   logic              alloc_found, rdy_found, hz_found;
   logic              alloc_fire, issue_fire, new_sleep;
   logic              dat_hit, dat_err, rsp_ack, rsp_in_range, rsp_hit, rsp_err;
   logic              unused_fields;

   assign unused_fields = ^{req_flit.opcode, req_flit.srcid, req_flit.return_txnid,
                            rsp_flit.srcid};

   // Per-entry status vectors and the same-line hazard compare against chain tails.
   always_comb begin
      free_vec  = '0;
      ready_vec = '0;
      match_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         free_vec[i]  = (state_q[i] == POCQ_FREE);
         ready_vec[i] = (state_q[i] == POCQ_READY);
         match_vec[i] = (HAZARD_EN != 0) && (state_q[i] != POCQ_FREE) && tail_q[i] &&
                        (addr_q[i][ADDR_W-1:LINE_LSB] == req_flit.addr[ADDR_W-1:LINE_LSB]);
      end
   end

   pocq_ffs #(.W(DEPTH)) u_free_ffs  (.vec(free_vec),  .idx(alloc_idx), .found(alloc_found));
   pocq_ffs #(.W(DEPTH)) u_issue_ffs (.vec(ready_vec), .idx(rdy_idx),   .found(rdy_found));
   pocq_ffs #(.W(DEPTH)) u_hz_ffs    (.vec(match_vec), .idx(hz_idx),    .found(hz_found));

   assign full        = (count_q == (IDX_W+1)'(DEPTH));
   assign empty       = (count_q == '0);
   assign count       = count_q;
   assign err         = err_q;
   assign req_ready   = !full;
   assign alloc_fire  = req_valid && req_ready && alloc_found;

   // A stalled selection is pinned so a newly READY lower entry cannot steal it.
   assign sel_idx     = hold_vld_q ? hold_idx_q : rdy_idx;
   assign snreq_valid = rdy_found;
   assign issue_fire  = snreq_valid && snreq_ready;

   // Data and ack decode; an ack colliding with data for the same entry is refused.
   always_comb begin
      rsp_idx      = rsp_flit.txnid[IDX_W-1:0];
      rsp_in_range = (int'(rsp_flit.txnid) < DEPTH);
      dat_hit      = dat_valid && (state_q[dat_txnid] == POCQ_ISSUED);
      dat_err      = dat_valid && !dat_hit;
      rsp_ack      = rsp_valid && (rsp_flit.opcode == RSP_COMPACK);
      rsp_hit      = rsp_ack && rsp_in_range && (state_q[rsp_idx] == POCQ_WAIT_ACK) &&
                     !(dat_valid && (dat_txnid == rsp_idx));
      rsp_err      = rsp_ack && !rsp_hit;
   end

   // One-hot event vectors so the entry update loop stays a plain per-bit test.
   always_comb begin
      alloc_oh  = '0;
      issue_oh  = '0;
      dat_oh    = '0;
      retire_oh = '0;
      hz_oh     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         alloc_oh[i]  = alloc_fire && (alloc_idx == IDX_W'(i));
         issue_oh[i]  = issue_fire && (sel_idx == IDX_W'(i));
         dat_oh[i]    = dat_hit && (dat_txnid == IDX_W'(i));
         retire_oh[i] = rsp_hit && (rsp_idx == IDX_W'(i));
         hz_oh[i]     = alloc_fire && hz_found && (hz_idx == IDX_W'(i));
      end
      // If the line's current tail retires this cycle there is nothing to wait on.
      new_sleep = hz_found && !retire_oh[hz_idx];
   end

   // Outgoing ReadNoSnp built from the selected entry.
   always_comb begin
      snreq_flit              = '0;
      snreq_flit.opcode       = OPC_READNOSNP;
      snreq_flit.addr         = addr_q[sel_idx];
      snreq_flit.txnid        = TXN_W'(sel_idx);
      snreq_flit.return_txnid = txn_q[sel_idx];
   end

   // Debug view of every entry's lifecycle state.
   always_comb begin
      dbg_state = '0;
      for (int i = 0; i < DEPTH; i++) begin
         dbg_state[i] = state_q[i];
      end
   end

   // Entry lifecycle, occupancy count, issue hold and error pulse.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i]   <= POCQ_FREE;
            addr_q[i]    <= '0;
            txn_q[i]     <= '0;
            blocker_q[i] <= '0;
         end
         tail_q     <= '0;
         count_q    <= '0;
         hold_vld_q <= 1'b0;
         hold_idx_q <= '0;
         err_q      <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc_oh[i]) begin
               state_q[i]   <= new_sleep ? POCQ_SLEEP : POCQ_READY;
               addr_q[i]    <= req_flit.addr;
               txn_q[i]     <= req_flit.txnid;
               blocker_q[i] <= hz_idx;
               tail_q[i]    <= 1'b1;
            end else begin
               case (state_q[i])
                  POCQ_SLEEP:    if (retire_oh[blocker_q[i]]) state_q[i] <= POCQ_READY;
                  POCQ_READY:    if (issue_oh[i])             state_q[i] <= POCQ_ISSUED;
                  POCQ_ISSUED:   if (dat_oh[i])               state_q[i] <= POCQ_WAIT_ACK;
                  POCQ_WAIT_ACK: if (retire_oh[i])            state_q[i] <= POCQ_FREE;
                  default:       ;
               endcase
               if (retire_oh[i] || hz_oh[i]) tail_q[i] <= 1'b0;
            end
         end
         count_q    <= count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(rsp_hit);
         hold_vld_q <= snreq_valid && !snreq_ready;
         hold_idx_q <= sel_idx;
         err_q      <= dat_err || rsp_err;
      end
   end

`ifndef SYNTHESIS
   // Chain sanity: at most one tail per line, and a sleeper's blocker is live.
   always_ff @(posedge clock) begin
      if (reset) begin
         assert ($countones(match_vec) <= 1);
         for (int i = 0; i < DEPTH; i++) begin
            if (state_q[i] == POCQ_SLEEP) assert (state_q[blocker_q[i]] != POCQ_FREE);
         end
      end
   end
`endif

endmodule
